// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Consumers: dmem_arbiter, rr_picker.
package dmem_pkg;

  // funct3 size/sign encodings, shared by loads and stores
  localparam logic [2:0] BYTE   = 3'b000;
  localparam logic [2:0] HALF   = 3'b001;
  localparam logic [2:0] WORD   = 3'b010;
  localparam logic [2:0] BYTE_U = 3'b100;
  localparam logic [2:0] HALF_U = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        write;
    logic [2:0]  funct3;
  } mem_req_t;

  // Halfword accesses need addr[0]==0 and word accesses need addr[1:0]==0.
  // funct3[1:0] carries the size for both the signed and unsigned forms.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [31:0] addr);
    case (funct3[1:0])
      2'b01:   return addr[0];
      2'b10:   return |addr[1:0];
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_picker.sv
// rr_picker: combinational two-way winner select.
// PRIO_MODE 0 = round-robin on rr_ptr_i, 1 = port 1 wins ties.
module rr_picker #(
  parameter int PRIO_MODE = 0
) (
  input  logic [1:0] req_valid_i,
  input  logic       rr_ptr_i,
  output logic       grant_valid_o,
  output logic       winner_o
);

  // Pick the winning port; only a tie consults the priority mode
  // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
  always_comb begin
    grant_valid_o = |req_valid_i;
    winner_o      = 1'b0;
    case (req_valid_i)
      2'b01:   winner_o = 1'b0;
      2'b10:   winner_o = 1'b1;
      2'b11:   winner_o = (PRIO_MODE == 1) ? 1'b1 : rr_ptr_i;
      default: winner_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester arbiter/sequencer in front of the shared
// data_memory port. Port 0 = fetch/debug, port 1 = load_store_unit.
// Flow: IDLE (grant) -> ACCESS (memory driven until mem_ready or timeout)
//       -> RESP (one-cycle response pulse to the owner) -> IDLE.
// Optional: define DMEM_ARB_MISALIGN_EN to reject misaligned halfword/word
// requests at grant time, answering with resp_err without touching memory.
module dmem_arbiter #(
  parameter int PRIO_MODE      = 0,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [1:0][31:0] req_addr,
  input  logic [1:0][31:0] req_wdata,
  input  logic [1:0]       req_write,
  input  logic [1:0][2:0]  req_funct3,
  output logic [1:0]       resp_valid,
  output logic [31:0]      resp_rdata,
  output logic             resp_err,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_write_data,
  output logic             mem_write,
  output logic             mem_read,
  output logic [2:0]       mem_funct3,
  input  logic [31:0]      mem_read_data,
  input  logic             mem_ready,
  output logic             busy
);

  import dmem_pkg::*;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  arb_state_t       state_q;
  logic             rr_ptr_q;
  logic             owner_q;
  mem_req_t         req_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       resp_valid_q;
  logic [31:0]      resp_rdata_q;
  logic             resp_err_q;

  logic             grant_valid;
  logic             winner;
  mem_req_t         sel_req;
  logic             in_access;

  rr_picker #(
    .PRIO_MODE(PRIO_MODE)
  ) u_picker (
    .req_valid_i  (req_valid),
    .rr_ptr_i     (rr_ptr_q),
    .grant_valid_o(grant_valid),
    .winner_o     (winner)
  );

  // Winner's request fields and the same-cycle accept pulse (IDLE only)
  always_comb begin
    sel_req.addr   = req_addr[winner];
    sel_req.wdata  = req_wdata[winner];
    sel_req.write  = req_write[winner];
    sel_req.funct3 = req_funct3[winner];
    req_ready      = '0;
    if (!rst && state_q == IDLE && grant_valid) req_ready[winner] = 1'b1;
  end

  // Memory side is a pure decode of registered state, so it stays stable across ACCESS
  assign in_access      = (state_q == ACCESS);
  assign mem_addr       = in_access ? req_q.addr   : '0;
  assign mem_write_data = in_access ? req_q.wdata  : '0;
  assign mem_funct3     = in_access ? req_q.funct3 : '0;
  assign mem_write      = in_access &  req_q.write;
  assign mem_read       = in_access & ~req_q.write;
  assign busy           = (state_q != IDLE);
  assign resp_valid     = resp_valid_q;
  assign resp_rdata     = resp_rdata_q;
  assign resp_err       = resp_err_q;

  // Arbitration FSM; reset abandons any transaction in flight without a response
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= 1'b0;
      owner_q      <= 1'b0;
      req_q        <= '0;
      cnt_q        <= '0;
      resp_valid_q <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_valid) begin
            req_q    <= sel_req;
            owner_q  <= winner;
            rr_ptr_q <= ~winner;
            cnt_q    <= '0;
`ifdef DMEM_ARB_MISALIGN_EN
            if (is_misaligned(sel_req.funct3, sel_req.addr)) begin
              resp_valid_q[winner] <= 1'b1;
              resp_rdata_q         <= '0;
              resp_err_q           <= 1'b1;
              state_q              <= RESP;
            end else begin
              state_q <= ACCESS;
            end
`else
            state_q <= ACCESS;
`endif
          end
        end
        ACCESS: begin
          // mem_ready takes precedence over a timeout landing in the same cycle
          if (mem_ready) begin
            resp_valid_q[owner_q] <= 1'b1;
            resp_rdata_q          <= req_q.write ? 32'd0 : mem_read_data;
            resp_err_q            <= 1'b0;
            state_q               <= RESP;
          end else if (cnt_q == CNT_LAST) begin
            resp_valid_q[owner_q] <= 1'b1;
            resp_rdata_q          <= '0;
            resp_err_q            <= 1'b1;
            state_q               <= RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RESP: begin
          resp_valid_q <= '0;
          resp_rdata_q <= '0;
          resp_err_q   <= 1'b0;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter. Two instances share all inputs:
// dut uses round-robin, dut_p1 uses fixed priority (port 1 wins ties).
module tb_dmem_arbiter;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req_valid;
  logic [1:0][31:0] req_addr;
  logic [1:0][31:0] req_wdata;
  logic [1:0]       req_write;
  logic [1:0][2:0]  req_funct3;
  logic [31:0]      mem_read_data;
  logic             mem_ready;

  logic [1:0]  req_ready,  req_ready_p1;
  logic [1:0]  resp_valid, resp_valid_p1;
  logic [31:0] resp_rdata, resp_rdata_p1;
  logic        resp_err,   resp_err_p1;
  logic [31:0] mem_addr,   mem_addr_p1;
  logic [31:0] mem_wd,     mem_wd_p1;
  logic        mem_write,  mem_write_p1;
  logic        mem_read,   mem_read_p1;
  logic [2:0]  mem_funct3, mem_funct3_p1;
  logic        busy,       busy_p1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.PRIO_MODE(0), .TIMEOUT_CYCLES(16), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_write(req_write),
    .req_funct3(req_funct3), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_addr(mem_addr), .mem_write_data(mem_wd),
    .mem_write(mem_write), .mem_read(mem_read), .mem_funct3(mem_funct3),
    .mem_read_data(mem_read_data), .mem_ready(mem_ready), .busy(busy)
  );

  dmem_arbiter #(.PRIO_MODE(1), .TIMEOUT_CYCLES(16), .CNT_W(8)) dut_p1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_p1),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_write(req_write),
    .req_funct3(req_funct3), .resp_valid(resp_valid_p1), .resp_rdata(resp_rdata_p1),
    .resp_err(resp_err_p1), .mem_addr(mem_addr_p1), .mem_write_data(mem_wd_p1),
    .mem_write(mem_write_p1), .mem_read(mem_read_p1), .mem_funct3(mem_funct3_p1),
    .mem_read_data(mem_read_data), .mem_ready(mem_ready), .busy(busy_p1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; return 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".req_ready"},  32'(req_ready),  32'd0);
    check({tag, ".resp_valid"}, 32'(resp_valid), 32'd0);
    check({tag, ".resp_rdata"}, resp_rdata,      32'd0);
    check({tag, ".resp_err"},   32'(resp_err),   32'd0);
    check({tag, ".mem_addr"},   mem_addr,        32'd0);
    check({tag, ".mem_wdata"},  mem_wd,          32'd0);
    check({tag, ".mem_rw"},     32'({mem_write, mem_read}), 32'd0);
    check({tag, ".mem_funct3"}, 32'(mem_funct3), 32'd0);
    check({tag, ".busy"},       32'(busy),       32'd0);
  endtask

  initial begin
    logic [1:0] exp_rr [3];
    exp_rr = '{2'b01, 2'b10, 2'b01};

    rst = 1'b1; req_valid = '0; req_addr = '0; req_wdata = '0; req_write = '0;
    req_funct3 = '0; mem_read_data = '0; mem_ready = 1'b0;

    // ---- reset state ----
    tick(); tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();
    check_all_zero("post_reset_idle");

    // ---- port 1 load, mem_ready in first ACCESS cycle ----
    req_valid = 2'b10; req_addr[1] = 32'h10; req_funct3[1] = 3'b010; req_write[1] = 1'b0;
    #1;
    check("load.T.req_ready", 32'(req_ready), 32'h2);
    check("load.T.busy", 32'(busy), 32'd0);
    tick();
    req_valid = 2'b00; mem_ready = 1'b1; mem_read_data = 32'hDEADBEEF;
    #1;
    check("load.T1.mem_read", 32'(mem_read), 32'd1);
    check("load.T1.mem_write", 32'(mem_write), 32'd0);
    check("load.T1.mem_addr", mem_addr, 32'h10);
    check("load.T1.mem_funct3", 32'(mem_funct3), 32'h2);
    check("load.T1.busy", 32'(busy), 32'd1);
    check("load.T1.req_ready", 32'(req_ready), 32'd0);
    tick();
    mem_ready = 1'b0;
    #1;
    check("load.T2.resp_valid", 32'(resp_valid), 32'h2);
    check("load.T2.resp_rdata", resp_rdata, 32'hDEADBEEF);
    check("load.T2.resp_err", 32'(resp_err), 32'd0);
    check("load.T2.mem_read", 32'(mem_read), 32'd0);
    check("load.T2.busy", 32'(busy), 32'd1);
    tick();
    check("load.T3.resp_valid", 32'(resp_valid), 32'd0);
    check("load.T3.busy", 32'(busy), 32'd0);

    // ---- both ports valid: round-robin vs fixed priority, 3 rounds ----
    req_valid = 2'b11; mem_ready = 1'b1;
    req_addr[0] = 32'h100; req_funct3[0] = 3'b010; req_write[0] = 1'b0;
    for (int r = 0; r < 3; r++) begin
      #1;
      check($sformatf("rr%0d.ready", r), 32'(req_ready), 32'(exp_rr[r]));
      check($sformatf("fp%0d.ready", r), 32'(req_ready_p1), 32'h2);
      tick();
      check($sformatf("rr%0d.access_ready", r), 32'(req_ready), 32'd0);
      tick();
      check($sformatf("rr%0d.resp_valid", r), 32'(resp_valid), 32'(exp_rr[r]));
      check($sformatf("fp%0d.resp_valid", r), 32'(resp_valid_p1), 32'h2);
      check($sformatf("rr%0d.resp_ready", r), 32'(req_ready), 32'd0);
      if (r == 2) req_valid = 2'b00;
      tick();
    end
    mem_ready = 1'b0;

    // ---- port 0 store, mem_ready after 4 wait cycles ----
    req_valid = 2'b01; req_addr[0] = 32'h20; req_wdata[0] = 32'h12345678;
    req_write[0] = 1'b1; req_funct3[0] = 3'b010; mem_read_data = 32'hFFFFFFFF;
    #1;
    check("st.T.req_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = 2'b00;
    for (int i = 0; i < 5; i++) begin
      mem_ready = (i == 4);
      #1;
      check($sformatf("st.acc%0d.mem_write", i), 32'(mem_write), 32'd1);
      check($sformatf("st.acc%0d.mem_read", i), 32'(mem_read), 32'd0);
      check($sformatf("st.acc%0d.mem_addr", i), mem_addr, 32'h20);
      check($sformatf("st.acc%0d.mem_wdata", i), mem_wd, 32'h12345678);
      check($sformatf("st.acc%0d.mem_funct3", i), 32'(mem_funct3), 32'h2);
      check($sformatf("st.acc%0d.resp_valid", i), 32'(resp_valid), 32'd0);
      tick();
    end
    mem_ready = 1'b0;
    #1;
    check("st.resp_valid", 32'(resp_valid), 32'h1);
    check("st.resp_rdata", resp_rdata, 32'd0);
    check("st.resp_err", 32'(resp_err), 32'd0);
    check("st.mem_write", 32'(mem_write), 32'd0);
    tick();

    // ---- timeout: mem_ready never comes, exactly 16 ACCESS cycles ----
    req_valid = 2'b10; req_addr[1] = 32'h40; req_write[1] = 1'b0; req_funct3[1] = 3'b010;
    #1;
    check("to.T.req_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = 2'b00;
    for (int i = 0; i < 16; i++) begin
      #1;
      check($sformatf("to.acc%0d.mem_read", i), 32'(mem_read), 32'd1);
      check($sformatf("to.acc%0d.resp_valid", i), 32'(resp_valid), 32'd0);
      tick();
    end
    check("to.resp_valid", 32'(resp_valid), 32'h2);
    check("to.resp_err", 32'(resp_err), 32'd1);
    check("to.resp_rdata", resp_rdata, 32'd0);
    check("to.mem_read", 32'(mem_read), 32'd0);
    tick();
    check("to.idle.busy", 32'(busy), 32'd0);
    check("to.idle.resp_valid", 32'(resp_valid), 32'd0);

    // ---- reset in the 2nd ACCESS cycle ----
    req_valid = 2'b01; req_addr[0] = 32'h50; req_write[0] = 1'b0; req_funct3[0] = 3'b010;
    tick();
    req_valid = 2'b00;
    tick();
    check("rst.acc2.mem_read", 32'(mem_read), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check_all_zero("rst.after");
    tick();
    check("rst.after2.resp_valid", 32'(resp_valid), 32'd0);
    check("rst.after2.busy", 32'(busy), 32'd0);
    req_valid = 2'b10; req_addr[1] = 32'h60; req_write[1] = 1'b0; req_funct3[1] = 3'b000;
    mem_ready = 1'b1; mem_read_data = 32'hCAFEF00D;
    #1;
    check("rst.later.req_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = 2'b00;
    #1;
    check("rst.later.mem_addr", mem_addr, 32'h60);
    tick();
    mem_ready = 1'b0;
    #1;
    check("rst.later.resp_valid", 32'(resp_valid), 32'h2);
    check("rst.later.resp_rdata", resp_rdata, 32'hCAFEF00D);
    check("rst.later.resp_err", 32'(resp_err), 32'd0);
    tick();

    // ---- LW at 0x22 (misaligned word) ----
    req_valid = 2'b01; req_addr[0] = 32'h22; req_write[0] = 1'b0; req_funct3[0] = 3'b010;
    mem_read_data = 32'h0BADF00D;
    #1;
    check("mis.T.req_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = 2'b00;
`ifdef DMEM_ARB_MISALIGN_EN
    mem_ready = 1'b1;
    #1;
    check("mis.T1.mem_read", 32'(mem_read), 32'd0);
    check("mis.T1.resp_valid", 32'(resp_valid), 32'h1);
    check("mis.T1.resp_err", 32'(resp_err), 32'd1);
    check("mis.T1.resp_rdata", resp_rdata, 32'd0);
    tick();
    mem_ready = 1'b0;
    check("mis.T2.mem_read", 32'(mem_read), 32'd0);
    check("mis.T2.busy", 32'(busy), 32'd0);
`else
    mem_ready = 1'b1;
    #1;
    check("mis.T1.mem_read", 32'(mem_read), 32'd1);
    check("mis.T1.mem_addr", mem_addr, 32'h22);
    tick();
    mem_ready = 1'b0;
    check("mis.T2.resp_valid", 32'(resp_valid), 32'h1);
    check("mis.T2.resp_err", 32'(resp_err), 32'd0);
    check("mis.T2.resp_rdata", resp_rdata, 32'h0BADF00D);
`endif
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single shared data_memory port.
- Port 0 serves the instruction-fetch or debug path. Port 1 serves load_store_unit.
- Accepts one request at a time, drives the memory-side signals stable until mem_ready, and returns a one-cycle response pulse to the owning requester.
- Sits between the MEM-stage requesters and data_memory; its mem_busy-style output feeds the pipeline stall logic.

Parameters:
- PRIO_MODE, 0, 0 = round-robin between ports; 1 = fixed priority, port 1 always wins ties.
- TIMEOUT_CYCLES, 16, max cycles in ACCESS before abort with error; range 2..255.
- CNT_W, 8, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  [1:0]  per-port request valid.
- req_ready  out  [1:0]  per-port one-cycle accept pulse.
- req_addr  in  [1:0][31:0]  byte address.
- req_wdata  in  [1:0][31:0]  store data.
- req_write  in  [1:0]  1 = store, 0 = load.
- req_funct3  in  [1:0][2:0]  access size/sign (LB/LH/LW/LBU/LHU/SB/SH/SW encodings).
- resp_valid  out  [1:0]  one-cycle response pulse to the owner.
- resp_rdata  out  32  load data; 0 for stores and errors.
- resp_err  out  1  timeout or misalignment; valid only with resp_valid.
- mem_addr  out  32  to data_memory addr.
- mem_write_data  out  32  to data_memory write_data.
- mem_write  out  1  to data_memory mem_write.
- mem_read  out  1  to data_memory mem_read.
- mem_funct3  out  3  to data_memory funct3.
- mem_read_data  in  32  from data_memory read_data.
- mem_ready  in  1  from data_memory mem_ready.
- busy  out  1  high in ACCESS and RESP.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset:
  - State = IDLE, rr_ptr = 0.
  - All outputs 0: req_ready, resp_valid, resp_rdata, resp_err, mem_*, busy.
  - Reset mid-transaction abandons the transaction; no response is ever issued for it.
- FSM states: IDLE -> ACCESS -> RESP -> IDLE.
- IDLE:
  - No req_valid: stay in IDLE.
  - One req_valid: that port wins.
  - Both req_valid: PRIO_MODE=0 picks the port rr_ptr points to; PRIO_MODE=1 picks port 1.
  - In the same cycle: req_ready[winner]=1, and addr/wdata/write/funct3 plus owner are latched.
  - Next state is ACCESS; rr_ptr <= ~winner.
  - The losing port's req_ready stays 0. It must hold req_valid and its fields.
- ACCESS:
  - mem_addr, mem_write_data and mem_funct3 come from the latched values.
  - mem_write = latched write; mem_read = ~latched write. Both held constant.
  - Timeout counter starts at 0 and increments each cycle.
  - On mem_ready: capture mem_read_data (forced to 0 for stores), resp_err=0, go to RESP.
  - Counter == TIMEOUT_CYCLES-1 without mem_ready: resp_rdata=0, resp_err=1, go to RESP.
  - If mem_ready and timeout occur in the same cycle, mem_ready wins.
- RESP:
  - mem_write = mem_read = 0.
  - resp_valid[owner]=1 for exactly one cycle, with resp_rdata and resp_err.
  - Next state is IDLE. No new grant in this cycle; earliest next grant is the following IDLE cycle.
- mem_ready is ignored outside ACCESS.
- Minimum latency: accept at cycle T, memory driven at T+1, mem_ready at T+1, resp_valid at T+2. Back-to-back throughput is one transaction per 3 cycles.
- req_ready is only asserted in IDLE, so a request arriving during ACCESS or RESP waits.
- The same-cycle requester rule applies to both ports.

Optional Feature:
- Macro: DMEM_ARB_MISALIGN_EN.
- Defined:
  - At grant, the latched request is checked: halfword with addr[0]!=0, or word with addr[1:0]!=0, is misaligned.
  - Misaligned requests skip ACCESS: IDLE -> RESP with resp_err=1 and resp_rdata=0.
  - mem_read and mem_write are never asserted for them.
- Undefined: no check; every request goes through ACCESS.

Decomposition:
- Shared package dmem_pkg:
  - Funct3 constants: BYTE, HALF, WORD, BYTE_U, HALF_U.
  - arb_state_t enum: IDLE, ACCESS, RESP.
  - mem_req_t struct: addr, wdata, write, funct3.
- One sub-module, rr_picker: combinational 2-way winner select from req_valid, rr_ptr and PRIO_MODE.

Test Plan:
- Port 1 load: addr=0x10, funct3=010; memory returns 0xDEADBEEF with mem_ready in the first ACCESS cycle -> req_ready[1] at T, mem_read=1 at T+1, resp_valid[1]=1 with rdata=0xDEADBEEF at T+2.
- Both ports hold req_valid, PRIO_MODE=0, three back-to-back rounds -> grants in order port 0, port 1, port 0, 3 cycles apart. With PRIO_MODE=1 -> port 1 every time while it is valid.
- Port 0 store: addr=0x20, wdata=0x12345678, mem_ready delayed 4 cycles -> mem_* stable for all 5 ACCESS cycles; resp_valid[0] with rdata=0 and err=0.
- mem_ready never asserted, TIMEOUT_CYCLES=16 -> exactly 16 ACCESS cycles, then resp_err=1 and rdata=0; FSM back in IDLE.
- rst pulsed in the 2nd ACCESS cycle -> next cycle all outputs 0 and no resp_valid. A later request completes normally.
- DMEM_ARB_MISALIGN_EN defined, LW addr=0x22 -> mem_read never asserted; resp_err=1 at T+1.
